rgb_sinp: RTL and testbench

Serial input decoder for WS2812b-style single-wire LED streams, the receive-side counterpart of the RGBW serial output stage. It samples the serial line at 96 MHz, classifies each high pulse as a "0" or "1" bit by width, assembles 24-bit G-R-B pixels, and detects stream-reset (long low). Each pixel and each stream-reset is written as a 32-bit status/colour word into the FIFO that feeds the RGBW conversion and output path.

---
 rtl/rgb_sinp.sv | 234 +++++++++++++++++++++++
 tb/tb_rgb_sinp.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_sinp.sv
// rgb_sinp: receive-side decoder for WS2812b-style single-wire LED streams.
//
// The serial line is synchronised and edge-detected. Each high pulse is
// timed and classified as a "0" or "1" bit by width. Bits are assembled
// MSB-first into 24-bit G-R-B pixels. A long low on the line is a
// stream-reset. Every pixel and every stream-reset becomes one 32-bit word
// written into a FIFO.
//
// Word layout: [31] valid, [30] stream_reset, [29:24] zero, [23:16] G,
//              [15:8] R, [7:0] B.
//
// Ports:
//   clk               clock (96 MHz, same domain as FIFO write clock)
//   rst               synchronous active-high reset
//   in_sig            asynchronous serial input
//   in_wr_fifo_full   FIFO full; a word presented while full is dropped
//   out_wr_fifo_en    one-clock write strobe per word
//   out_wr_fifo_data  word, valid in the same clock as out_wr_fifo_en
//   out_overflow      sticky until rst: a word was dropped on full
//
// Optional feature: define RGB_SINP_GLITCH_FILTER_EN to add a 3-sample
// stable filter after the synchroniser (pulses/gaps of 1-2 clocks vanish,
// widths preserved, all write latencies grow by 2 clocks).

module rgb_sinp #(
    parameter int unsigned T_THRESH    = 58,
    parameter int unsigned MIN_HIGH    = 8,
    parameter int unsigned RST_LOW     = 4800,
    parameter int unsigned COUNTER_MAX = 7800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_sig,
    input  logic        in_wr_fifo_full,
    output logic        out_wr_fifo_en,
    output logic [31:0] out_wr_fifo_data,
    output logic        out_overflow
);

    localparam int unsigned CNT_W = $clog2(COUNTER_MAX + 1);

    typedef enum logic [1:0] {
        StIdle,
        StLowWait,
        StHigh,
        StStuck
    } state_e;

    // ------------------------------------------------------------------
    // Input synchroniser (and optional stable filter)
    // ------------------------------------------------------------------
    logic sync1_q, sync2_q;
    logic sig_s, sig_p_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= in_sig;
            sync2_q <= sync1_q;
        end
    end

`ifdef RGB_SINP_GLITCH_FILTER_EN
    logic sync3_q, filt_q;

    // sync1/sync2/sync3 hold three consecutive samples; the filtered level
    // only follows once all three agree, adding exactly two clocks of delay.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync3_q <= 1'b0;
            filt_q  <= 1'b0;
        end else begin
            sync3_q <= sync2_q;
            if ((sync1_q == sync2_q) && (sync2_q == sync3_q)) begin
                filt_q <= sync2_q;
            end
        end
    end

    assign sig_s = filt_q;
`else
    assign sig_s = sync2_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_p_q <= 1'b0;
        end else begin
            sig_p_q <= sig_s;
        end
    end

    logic rise, fall;
    assign rise = sig_s & ~sig_p_q;
    assign fall = ~sig_s & sig_p_q;

    // ------------------------------------------------------------------
    // Width counter: on a fall cycle cnt_q equals the exact number of
    // clocks the line was high; cnt_d is the length of the current level
    // including this clock.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (rise || fall) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != CNT_W'(COUNTER_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Decode FSM
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [23:0] sr_q, sr_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic        armed_q, armed_d;
    logic        wr_req_q, wr_req_d;
    logic [31:0] wr_data_q, wr_data_d;

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bitcnt_d  = bitcnt_q;
        armed_d   = armed_q;
        wr_req_d  = 1'b0;
        wr_data_d = wr_data_q;

        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StHigh;
                    armed_d = 1'b1;
                end
            end

            StLowWait: begin
                if (rise) begin
                    state_d = StHigh;
                    armed_d = 1'b1;
                end else if (cnt_d == CNT_W'(RST_LOW)) begin
                    // Stream-reset; any partial pixel is dropped silently.
                    if (armed_q) begin
                        wr_req_d  = 1'b1;
                        wr_data_d = 32'hC000_0000;
                    end
                    armed_d  = 1'b0;
                    bitcnt_d = '0;
                    state_d  = StIdle;
                end
            end

            StHigh: begin
                if (fall) begin
                    state_d = StLowWait;
                    if (cnt_q >= CNT_W'(MIN_HIGH)) begin
                        sr_d = {sr_q[22:0], (cnt_q >= CNT_W'(T_THRESH))};
                        if (bitcnt_q == 5'd23) begin
                            wr_req_d  = 1'b1;
                            wr_data_d = {8'h80, sr_d};
                            bitcnt_d  = '0;
                        end else begin
                            bitcnt_d = bitcnt_q + 5'd1;
                        end
                    end
                end else if (cnt_d == CNT_W'(RST_LOW)) begin
                    // Line stuck high: abandon the partial pixel.
                    state_d  = StStuck;
                    bitcnt_d = '0;
                end
            end

            StStuck: begin
                if (fall) begin
                    state_d = StLowWait;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            sr_q      <= '0;
            bitcnt_q  <= '0;
            armed_q   <= 1'b0;
            wr_req_q  <= 1'b0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bitcnt_q  <= bitcnt_d;
            armed_q   <= armed_d;
            wr_req_q  <= wr_req_d;
            wr_data_q <= wr_data_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO write stage: drop on full and remember that it happened.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_wr_fifo_en   <= 1'b0;
            out_wr_fifo_data <= '0;
            out_overflow     <= 1'b0;
        end else begin
            out_wr_fifo_en <= wr_req_q & ~in_wr_fifo_full;
            if (wr_req_q && !in_wr_fifo_full) begin
                out_wr_fifo_data <= wr_data_q;
            end
            if (wr_req_q && in_wr_fifo_full) begin
                out_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rgb_sinp.sv
// Testbench for rgb_sinp. Drives WS2812b-style bit streams and compares
// every FIFO write (data and clock of arrival) with a run-length model of
// the line protocol, plus directed constants for the key scenarios.

module tb_rgb_sinp;

    localparam int unsigned T_THRESH    = 6;
    localparam int unsigned MIN_HIGH    = 2;
    localparam int unsigned RST_LOW     = 40;
    localparam int unsigned COUNTER_MAX = 60;

`ifdef RGB_SINP_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_sig;
    logic        full;
    logic        en;
    logic [31:0] data;
    logic        ovf;

    rgb_sinp #(
        .T_THRESH   (T_THRESH),
        .MIN_HIGH   (MIN_HIGH),
        .RST_LOW    (RST_LOW),
        .COUNTER_MAX(COUNTER_MAX)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_sig          (in_sig),
        .in_wr_fifo_full (full),
        .out_wr_fifo_en  (en),
        .out_wr_fifo_data(data),
        .out_overflow    (ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_e0 = 0;

    logic [31:0] exp_data[$];
    int          exp_cyc[$];
    logic [31:0] obs_data[$];
    int          obs_cyc[$];
    logic [31:0] pend_data[$];
    int          pend_cyc[$];
    bit          model_ovf = 1'b0;

    // ------------------------------------------------------------------
    // Reference model: works on run lengths of the sampled line level.
    // ------------------------------------------------------------------
    bit prev_lvl = 1'b0;
    int run_len = 0;
    bit armed = 1'b0;
    bit stuck = 1'b0;
    bit bitq[$];
    bit h1 = 1'b0, h2 = 1'b0, filt_lvl = 1'b0;

    always @(posedge clk) begin
        bit v;
        logic [23:0] pix;
        cyc++;
        if (rst) begin
            prev_lvl = 1'b0;
            run_len = 0;
            armed = 1'b0;
            stuck = 1'b0;
            bitq.delete();
            h1 = 1'b0;
            h2 = 1'b0;
            filt_lvl = 1'b0;
            pend_data.delete();
            pend_cyc.delete();
            model_ovf = 1'b0;
        end else begin
            while (pend_cyc.size() > 0 && pend_cyc[0] == cyc) begin
                if (full) model_ovf = 1'b1;
                else begin
                    exp_data.push_back(pend_data[0]);
                    exp_cyc.push_back(cyc);
                end
                void'(pend_data.pop_front());
                void'(pend_cyc.pop_front());
            end
            v = in_sig;
`ifdef RGB_SINP_GLITCH_FILTER_EN
            // Level only changes once three consecutive samples agree.
            if (v == h1 && h1 == h2) filt_lvl = v;
            h2 = h1;
            h1 = v;
            v = filt_lvl;
`endif
            if (v) begin
                if (!prev_lvl) begin
                    run_len = 1;
                    armed = 1'b1;
                    stuck = 1'b0;
                end else begin
                    run_len++;
                end
                if (run_len == int'(RST_LOW)) begin
                    stuck = 1'b1;
                    bitq.delete();
                end
            end else begin
                if (prev_lvl) begin
                    if (!stuck && run_len >= int'(MIN_HIGH)) begin
                        bitq.push_back(run_len >= int'(T_THRESH));
                        if (bitq.size() == 24) begin
                            for (int i = 0; i < 24; i++) pix[23-i] = bitq[i];
                            pend_data.push_back({8'h80, pix});
                            pend_cyc.push_back(cyc + 3);
                            bitq.delete();
                        end
                    end
                    run_len = 1;
                    stuck = 1'b0;
                end else begin
                    run_len++;
                    if (run_len == int'(RST_LOW)) begin
                        if (armed) begin
                            pend_data.push_back(32'hC000_0000);
                            pend_cyc.push_back(cyc + 3);
                        end
                        armed = 1'b0;
                        bitq.delete();
                    end
                end
            end
            prev_lvl = v;
        end
    end

    // Write monitor, sampled 1 time unit after the active edge.
    always @(posedge clk) begin
        #1;
        if (en === 1'b1) begin
            obs_data.push_back(data);
            obs_cyc.push_back(cyc);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all called on a negedge)
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic drive(input bit lvl, input int n);
        in_sig = lvl;
        repeat (n) @(negedge clk);
    endtask

    // gw > 0 splits a "0" bit's low gap with a gw-clock high glitch.
    task automatic send_bit(input bit b, input int gw);
        drive(1'b1, b ? 8 : 3);
        last_e0 = cyc + 1;
        if (gw > 0 && !b) begin
            drive(1'b0, 3);
            drive(1'b1, gw);
            drive(1'b0, 6 - gw);
        end else begin
            drive(1'b0, b ? 4 : 9);
        end
    endtask

    task automatic send_bits(input logic [23:0] p, input int nbits, input int gpos,
                             input int gw);
        for (int i = 23; i > 23 - nbits; i--) send_bit(p[i], (i == gpos) ? gw : 0);
    endtask

    task automatic compare_writes(input string tag, input int nk, input logic [31:0] k0,
                                  input logic [31:0] k1);
        int n;
        chk({tag, "_count"}, obs_data.size(), exp_data.size());
        if (nk >= 0) chk({tag, "_count_k"}, obs_data.size(), nk);
        n = (obs_data.size() < exp_data.size()) ? obs_data.size() : exp_data.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_data"}, obs_data[i], exp_data[i]);
            chk({tag, "_cycle"}, obs_cyc[i], exp_cyc[i]);
        end
        if (nk >= 1) chk({tag, "_word0"}, (obs_data.size() > 0) ? obs_data[0] : 'x, k0);
        if (nk >= 2) chk({tag, "_word1"}, (obs_data.size() > 1) ? obs_data[1] : 'x, k1);
        obs_data.delete();
        obs_cyc.delete();
        exp_data.delete();
        exp_cyc.delete();
    endtask

    // ------------------------------------------------------------------
    // Directed + randomised sequence
    // ------------------------------------------------------------------
    initial begin
        logic [23:0] p;
        int gpos;
        rst = 1'b1;
        in_sig = 1'b0;
        full = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_en", en, 1'b0);
        chk("reset_data", data, 32'h0);
        chk("reset_ovf", ovf, 1'b0);
        rst = 1'b0;
        drive(1'b0, 5);

        // First pixel and its latency.
        send_bits(24'h123456, 24, -1, 0);
        drive(1'b0, 10);
        chk("pix_latency", (obs_cyc.size() > 0) ? obs_cyc[0] : -1, last_e0 + LAT);
        compare_writes("pix1", 1, 32'h8012_3456, 32'h0);

        // Long low after a pixel: one stream-reset word, no more.
        drive(1'b0, 200);
        chk("rst_latency", (obs_cyc.size() > 0) ? obs_cyc[0] : -1,
            last_e0 + int'(RST_LOW) - 1 + LAT);
        compare_writes("stream_rst", 1, 32'hC000_0000, 32'h0);

        // Reset then idle low: no writes at all.
        rst = 1'b1;
        drive(1'b0, 3);
        rst = 1'b0;
        drive(1'b0, 200);
        chk("postrst_en", en, 1'b0);
        chk("postrst_data", data, 32'h0);
        chk("postrst_ovf", ovf, 1'b0);
        compare_writes("idle_after_rst", 0, 32'h0, 32'h0);

        // Partial pixel flushed by a stream-reset, then a full pixel.
        send_bits(24'hABC000, 12, -1, 0);
        drive(1'b0, 45);
        send_bits(24'hAABBCC, 24, -1, 0);
        drive(1'b0, 10);
        compare_writes("partial", 2, 32'hC000_0000, 32'h80AA_BBCC);

        // Pixel completes while the FIFO is full.
        full = 1'b1;
        send_bits(24'h0F0F0F, 24, -1, 0);
        drive(1'b0, 6);
        full = 1'b0;
        drive(1'b0, 10);
        chk("ovf_set", ovf, 1'b1);
        chk("ovf_model", ovf, model_ovf);
        compare_writes("full_drop", 0, 32'h0, 32'h0);
        drive(1'b0, 30);
        chk("ovf_sticky", ovf, 1'b1);
        compare_writes("full_after", 1, 32'hC000_0000, 32'h0);
        rst = 1'b1;
        drive(1'b0, 3);
        rst = 1'b0;
        drive(1'b0, 2);
        chk("ovf_cleared", ovf, 1'b0);

        // Short glitch inside a low gap is ignored.
        send_bits(24'h5A3C96, 24, 23, 1);
        drive(1'b0, 10);
        compare_writes("glitch1", 1, 32'h805A_3C96, 32'h0);
`ifdef RGB_SINP_GLITCH_FILTER_EN
        send_bits(24'h5A3C96, 24, 21, 2);
        drive(1'b0, 10);
        compare_writes("glitch2", 1, 32'h805A_3C96, 32'h0);
`endif

        // Random pixels, occasional glitch and FIFO-full.
        for (int k = 0; k < 8; k++) begin
            p = 24'($urandom);
            gpos = -1;
            for (int i = 0; i < 24; i++) if (!p[i] && $urandom_range(0, 3) == 0) gpos = i;
            full = ($urandom_range(0, 3) == 0);
            send_bits(p, 24, gpos, 1);
            drive(1'b0, 6);
            full = 1'b0;
            drive(1'b0, $urandom_range(5, 20));
            chk("rand_ovf", ovf, model_ovf);
            compare_writes("rand_pix", -1, 32'h0, 32'h0);
        end
        drive(1'b0, 60);
        compare_writes("rand_tail", 1, 32'hC000_0000, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
